uart_fifo_core: RTL and testbench
=================================

Name: uart_fifo_core

Overview:
Second-generation UART for the BSP. It adds a runtime-programmable baud divider, runtime frame format (5-8 data bits, parity none/even/odd, 1 or 2 stop bits), and parametrised TX/RX FIFOs with valid/ready handshakes. It also provides RTS/CTS hardware flow control, per-byte error tagging and a sticky overrun flag. It sits between the ESP32 link pins and the host-side register/bus logic.

Parameters:
FIFO_AW, 4, log2 of each FIFO depth (depth = 2^FIFO_AW = 16)
RTS_THRESH, 12, RX FIFO level at or above which RTS is deasserted (driven high)

Ports:
CLK  in  1  system clock
RST  in  1  reset, asynchronous, active-high
UART_TXD  out  1  serial transmit, idle high
UART_RXD  in  1  serial receive, asynchronous
UART_RTS  out  1  0 = this device ready to receive
UART_CTS  in  1  0 = far end ready to receive, asynchronous
CFG_DIV  in  16  clocks per bit; values below 4 are treated as 4
CFG_DATA_BITS  in  4  5..8; values below 5 are treated as 5, above 8 as 8
CFG_PARITY  in  2  0 none, 1 even, 2 odd, 3 treated as none
CFG_STOP2  in  1  1 = two stop bits on TX
FLOW_EN  in  1  1 = enable CTS gating and RTS generation
TX_DATA  in  8  byte to send; unused upper bits are ignored
TX_VALID  in  1  push request
TX_READY  out  1  TX FIFO not full
RX_DATA  out  8  head of RX FIFO; unused upper bits are 0
RX_PERR  out  1  parity error tag of the head entry
RX_FERR  out  1  frame (stop bit) error tag of the head entry
RX_VALID  out  1  RX FIFO not empty
RX_READY  in  1  pop request
RX_OVERRUN  out  1  sticky; a received byte was dropped
ERR_CLR  in  1  clears RX_OVERRUN
TX_LEVEL  out  FIFO_AW+1  TX FIFO occupancy
RX_LEVEL  out  FIFO_AW+1  RX FIFO occupancy

Behaviour:
- Reset values: UART_TXD=1, UART_RTS=1, TX_READY=1, RX_VALID=0, RX_DATA=0, RX_PERR=0, RX_FERR=0, RX_OVERRUN=0, levels=0. All FSMs go to IDLE and both FIFOs are emptied. A reset mid-frame aborts the frame; TXD returns high immediately.
- Synchronisers: UART_RXD and UART_CTS pass through 2-FF synchronisers, reset to 1.
- Config latch: CFG_* is latched at each frame start (TX and RX independently). Changes mid-frame do not affect the current frame.
- FIFOs: first-word-fall-through.
  - TX push on TX_VALID&TX_READY.
  - RX pop on RX_VALID&RX_READY.
  - Simultaneous push and pop leaves the level unchanged.
  - Pointers wrap modulo depth; the level distinguishes full from empty.
- TX FSM states: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
  - IDLE: leaves when the TX FIFO is non-empty and (!FLOW_EN or synced CTS==0). It pops one entry in the same cycle.
  - CTS is evaluated only in IDLE; a frame in progress always completes.
  - Each state holds TXD for exactly CFG_DIV clocks. TXD is registered and goes low the cycle after the IDLE exit.
  - Data is sent LSB first for CFG_DATA_BITS bits.
  - PARITY is skipped when parity is none. Even parity: parity bit = XOR of the data bits. Odd parity: its inverse.
  - STOP lasts 1×DIV, or 2×DIV when CFG_STOP2=1.
  - Back-to-back frames: no idle gap beyond the IDLE-to-START cycle.
- RX FSM states: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
  - IDLE: a falling edge of synced RXD starts a DIV/2 (floor) count into START.
  - START: at mid-bit, RXD high is a false start and returns to IDLE; otherwise DATA.
  - DATA and PARITY bits are sampled every DIV clocks thereafter.
  - STOP: sampled at mid-bit. 0 sets the frame-error tag. The FSM returns to IDLE right after the stop sample, so the next start edge can be detected in the remaining half bit.
  - The RX side checks only one stop bit.
- RX push: occurs in the stop-sample cycle with {data, perr, ferr}.
  - If the RX FIFO is full and no pop happens in the same cycle, the byte is dropped and RX_OVERRUN is set.
  - RX_OVERRUN stays set until ERR_CLR; if ERR_CLR and a new overrun coincide, the flag remains set.
- RTS: registered. UART_RTS = FLOW_EN & (RX_LEVEL >= RTS_THRESH). It takes effect one clock after the level change. A frame already in flight is still accepted.
- Divider counters are 16-bit, count DIV-1 down to 0, and reload on each bit boundary.

Test Plan:
- Loopback (TXD->RXD), DIV=8, 8N1, push 0xA5: TXD low for 8 clocks, then bits 1,0,1,0,0,1,0,1 each 8 clocks, then high. RX_VALID asserts with RX_DATA=0xA5, PERR=0, FERR=0.
- 7 data bits, odd parity, STOP2, push 0x3C: 7 data bits, parity bit = 1, stop high for 16 clocks. Loopback RX_DATA=0x3C with PERR=0.
- Inject a frame with wrong parity, then a frame with stop=0: first entry has PERR=1; second has FERR=1 and its data is still delivered.
- Glitch on RXD low for 3 clocks with DIV=16: false start; no push and RX_LEVEL stays 0.
- Hold RX_READY=0 and send 17 bytes (depth 16), FLOW_EN=1: RTS goes high after the 12th byte. The 17th byte is dropped, RX_OVERRUN=1 and RX_LEVEL=16. ERR_CLR clears the flag.
- FLOW_EN=1, CTS high, push 3 bytes: TXD stays idle and TX_LEVEL=3. Drop CTS: three back-to-back frames follow. Raise CTS mid-frame 2: frame 2 completes, frame 3 waits.

Source files
------------

// File: rtl/uart_fifo_core.sv
// ============================================================================
// uart_fifo_core : UART with runtime baud/frame format, TX/RX FWFT FIFOs,
//                  RTS/CTS flow control and per-byte error tagging.
// Revision 1.0
// ============================================================================
`default_nettype none

module uart_fifo_core #(
  parameter int FIFO_AW    = 4,
  parameter int RTS_THRESH = 12
) (
  input  logic               CLK,
  input  logic               RST,
  output logic               UART_TXD,
  input  logic               UART_RXD,
  output logic               UART_RTS,
  input  logic               UART_CTS,
  input  logic [15:0]        CFG_DIV,
  input  logic [3:0]         CFG_DATA_BITS,
  input  logic [1:0]         CFG_PARITY,
  input  logic               CFG_STOP2,
  input  logic               FLOW_EN,
  input  logic [7:0]         TX_DATA,
  input  logic               TX_VALID,
  output logic               TX_READY,
  output logic [7:0]         RX_DATA,
  output logic               RX_PERR,
  output logic               RX_FERR,
  output logic               RX_VALID,
  input  logic               RX_READY,
  output logic               RX_OVERRUN,
  input  logic               ERR_CLR,
  output logic [FIFO_AW:0]   TX_LEVEL,
  output logic [FIFO_AW:0]   RX_LEVEL
);

  localparam int               c_depth_n    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] c_depth      = c_depth_n[FIFO_AW:0];
  localparam logic [FIFO_AW:0] c_rts_thresh = RTS_THRESH[FIFO_AW:0];

  localparam logic [2:0] c_idle   = 3'd0;
  localparam logic [2:0] c_start  = 3'd1;
  localparam logic [2:0] c_data   = 3'd2;
  localparam logic [2:0] c_parity = 3'd3;
  localparam logic [2:0] c_stop   = 3'd4;

  // ---------------- synchronisers ----------------
  logic r_rxd_s1, r_rxd_s2, r_rxd_d;
  logic r_cts_s1, r_cts_s2;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rxd_s1 <= 1'b1;
      r_rxd_s2 <= 1'b1;
      r_rxd_d  <= 1'b1;
      r_cts_s1 <= 1'b1;
      r_cts_s2 <= 1'b1;
    end else begin
      r_rxd_s1 <= UART_RXD;
      r_rxd_s2 <= r_rxd_s1;
      r_rxd_d  <= r_rxd_s2;
      r_cts_s1 <= UART_CTS;
      r_cts_s2 <= r_cts_s1;
    end
  end

  // ---------------- clamped configuration ----------------
  logic [15:0] w_div;
  logic [2:0]  w_last;
  logic [7:0]  w_mask;
  logic        w_par_en, w_par_odd;

  always_comb begin
    w_div = (CFG_DIV < 16'd4) ? 16'd4 : CFG_DIV;
    if (CFG_DATA_BITS < 4'd5)      w_last = 3'd4;
    else if (CFG_DATA_BITS > 4'd8) w_last = 3'd7;
    else                           w_last = CFG_DATA_BITS[2:0] - 3'd1;
    w_mask    = 8'hFF >> (3'd7 - w_last);
    w_par_en  = (CFG_PARITY == 2'd1) | (CFG_PARITY == 2'd2);
    w_par_odd = (CFG_PARITY == 2'd2);
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]         r_tx_mem [0:c_depth_n-1];
  logic [FIFO_AW-1:0] r_tx_wr, r_tx_rd;
  logic [FIFO_AW:0]   r_tx_level;
  logic               w_tx_push, w_tx_pop;
  logic [7:0]         w_tx_head;
  logic [2:0]         r_tx_state;

  assign TX_READY  = (r_tx_level != c_depth);
  assign TX_LEVEL  = r_tx_level;
  assign w_tx_push = TX_VALID & TX_READY;
  assign w_tx_head = r_tx_mem[r_tx_rd];
  assign w_tx_pop  = (r_tx_state == c_idle) && (r_tx_level != '0) && (!FLOW_EN || !r_cts_s2);

  always_ff @(posedge CLK) begin
    if (w_tx_push) r_tx_mem[r_tx_wr] <= TX_DATA;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_tx_wr    <= '0;
      r_tx_rd    <= '0;
      r_tx_level <= '0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + 1'b1;
      if (w_tx_push && !w_tx_pop)      r_tx_level <= r_tx_level + 1'b1;
      else if (!w_tx_push && w_tx_pop) r_tx_level <= r_tx_level - 1'b1;
    end
  end

  // ---------------- TX FSM ----------------
  logic [15:0] r_tx_cnt, r_tx_div;
  logic [7:0]  r_tx_shift;
  logic [2:0]  r_tx_bit, r_tx_last;
  logic        r_tx_par_en, r_tx_par_bit, r_tx_stop2, r_tx_stop_2nd, r_txd;

  assign UART_TXD = r_txd;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_tx_state    <= c_idle;
      r_txd         <= 1'b1;
      r_tx_cnt      <= '0;
      r_tx_div      <= '0;
      r_tx_shift    <= '0;
      r_tx_bit      <= '0;
      r_tx_last     <= '0;
      r_tx_par_en   <= 1'b0;
      r_tx_par_bit  <= 1'b0;
      r_tx_stop2    <= 1'b0;
      r_tx_stop_2nd <= 1'b0;
    end else begin
      case (r_tx_state)
        c_idle: begin
          if (w_tx_pop) begin
            r_tx_state    <= c_start;
            r_txd         <= 1'b0;
            r_tx_div      <= w_div;
            r_tx_cnt      <= w_div - 16'd1;
            r_tx_shift    <= w_tx_head & w_mask;
            r_tx_last     <= w_last;
            r_tx_par_en   <= w_par_en;
            r_tx_par_bit  <= (^(w_tx_head & w_mask)) ^ w_par_odd;
            r_tx_stop2    <= CFG_STOP2;
            r_tx_stop_2nd <= 1'b0;
          end
        end
        c_start: begin
          if (r_tx_cnt == 16'd0) begin
            r_tx_state <= c_data;
            r_txd      <= r_tx_shift[0];
            r_tx_bit   <= '0;
            r_tx_cnt   <= r_tx_div - 16'd1;
          end else r_tx_cnt <= r_tx_cnt - 16'd1;
        end
        c_data: begin
          if (r_tx_cnt == 16'd0) begin
            r_tx_cnt <= r_tx_div - 16'd1;
            if (r_tx_bit == r_tx_last) begin
              r_tx_state <= r_tx_par_en ? c_parity : c_stop;
              r_txd      <= r_tx_par_en ? r_tx_par_bit : 1'b1;
            end else begin
              r_tx_bit   <= r_tx_bit + 3'd1;
              r_tx_shift <= r_tx_shift >> 1;
              r_txd      <= r_tx_shift[1];
            end
          end else r_tx_cnt <= r_tx_cnt - 16'd1;
        end
        c_parity: begin
          if (r_tx_cnt == 16'd0) begin
            r_tx_state <= c_stop;
            r_txd      <= 1'b1;
            r_tx_cnt   <= r_tx_div - 16'd1;
          end else r_tx_cnt <= r_tx_cnt - 16'd1;
        end
        c_stop: begin
          // Second stop bit is a re-run of the same state.
          if (r_tx_cnt == 16'd0) begin
            if (r_tx_stop2 && !r_tx_stop_2nd) begin
              r_tx_stop_2nd <= 1'b1;
              r_tx_cnt      <= r_tx_div - 16'd1;
            end else r_tx_state <= c_idle;
          end else r_tx_cnt <= r_tx_cnt - 16'd1;
        end
        default: begin
          r_tx_state <= c_idle;
          r_txd      <= 1'b1;
        end
      endcase
    end
  end

  // ---------------- RX FSM ----------------
  logic [2:0]  r_rx_state, r_rx_bit, r_rx_last;
  logic [15:0] r_rx_cnt, r_rx_div;
  logic [7:0]  r_rx_data;
  logic        r_rx_par_en, r_rx_par_odd, r_rx_perr;
  logic        w_rx_fall, w_rx_push;

  assign w_rx_fall = r_rxd_d & ~r_rxd_s2;
  assign w_rx_push = (r_rx_state == c_stop) && (r_rx_cnt == 16'd0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rx_state   <= c_idle;
      r_rx_cnt     <= '0;
      r_rx_div     <= '0;
      r_rx_bit     <= '0;
      r_rx_last    <= '0;
      r_rx_par_en  <= 1'b0;
      r_rx_par_odd <= 1'b0;
      r_rx_data    <= '0;
      r_rx_perr    <= 1'b0;
    end else begin
      case (r_rx_state)
        c_idle: begin
          if (w_rx_fall) begin
            r_rx_state   <= c_start;
            r_rx_div     <= w_div;
            r_rx_cnt     <= {1'b0, w_div[15:1]} - 16'd1;
            r_rx_last    <= w_last;
            r_rx_par_en  <= w_par_en;
            r_rx_par_odd <= w_par_odd;
            r_rx_data    <= '0;
            r_rx_perr    <= 1'b0;
            r_rx_bit     <= '0;
          end
        end
        c_start: begin
          if (r_rx_cnt == 16'd0) begin
            if (r_rxd_s2) r_rx_state <= c_idle;
            else begin
              r_rx_state <= c_data;
              r_rx_cnt   <= r_rx_div - 16'd1;
            end
          end else r_rx_cnt <= r_rx_cnt - 16'd1;
        end
        c_data: begin
          if (r_rx_cnt == 16'd0) begin
            r_rx_data[r_rx_bit] <= r_rxd_s2;
            r_rx_cnt            <= r_rx_div - 16'd1;
            if (r_rx_bit == r_rx_last) r_rx_state <= r_rx_par_en ? c_parity : c_stop;
            else r_rx_bit <= r_rx_bit + 3'd1;
          end else r_rx_cnt <= r_rx_cnt - 16'd1;
        end
        c_parity: begin
          if (r_rx_cnt == 16'd0) begin
            r_rx_perr  <= r_rxd_s2 ^ (^r_rx_data) ^ r_rx_par_odd;
            r_rx_state <= c_stop;
            r_rx_cnt   <= r_rx_div - 16'd1;
          end else r_rx_cnt <= r_rx_cnt - 16'd1;
        end
        c_stop: begin
          // Leave right after the mid-bit sample so a following start edge is seen.
          if (r_rx_cnt == 16'd0) r_rx_state <= c_idle;
          else r_rx_cnt <= r_rx_cnt - 16'd1;
        end
        default: r_rx_state <= c_idle;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  logic [9:0]         r_rx_mem [0:c_depth_n-1];
  logic [FIFO_AW-1:0] r_rx_wr, r_rx_rd;
  logic [FIFO_AW:0]   r_rx_level;
  logic               w_rx_full, w_rx_pop, w_rx_wr;
  logic [9:0]         w_rx_head;
  logic               r_overrun, r_rts;

  assign w_rx_full  = (r_rx_level == c_depth);
  assign RX_VALID   = (r_rx_level != '0);
  assign w_rx_pop   = RX_VALID & RX_READY;
  assign w_rx_wr    = w_rx_push & (!w_rx_full | w_rx_pop);
  assign w_rx_head  = r_rx_mem[r_rx_rd];
  assign RX_DATA    = RX_VALID ? w_rx_head[9:2] : 8'h00;
  assign RX_PERR    = RX_VALID & w_rx_head[1];
  assign RX_FERR    = RX_VALID & w_rx_head[0];
  assign RX_LEVEL   = r_rx_level;
  assign RX_OVERRUN = r_overrun;
  assign UART_RTS   = r_rts;

  always_ff @(posedge CLK) begin
    if (w_rx_wr) r_rx_mem[r_rx_wr] <= {r_rx_data, r_rx_perr, ~r_rxd_s2};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rx_wr    <= '0;
      r_rx_rd    <= '0;
      r_rx_level <= '0;
      r_overrun  <= 1'b0;
      r_rts      <= 1'b1;
    end else begin
      if (w_rx_wr)  r_rx_wr <= r_rx_wr + 1'b1;
      if (w_rx_pop) r_rx_rd <= r_rx_rd + 1'b1;
      if (w_rx_wr && !w_rx_pop)      r_rx_level <= r_rx_level + 1'b1;
      else if (!w_rx_wr && w_rx_pop) r_rx_level <= r_rx_level - 1'b1;
      if (w_rx_push && w_rx_full && !w_rx_pop) r_overrun <= 1'b1;
      else if (ERR_CLR)                        r_overrun <= 1'b0;
      r_rts <= FLOW_EN & (r_rx_level >= c_rts_thresh);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_fifo_core.sv
// ============================================================================
// tb_uart_fifo_core : scoreboard bench for uart_fifo_core (loopback + injection)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_uart_fifo_core;
  localparam int FIFO_AW = 4;

  logic              CLK = 1'b0;
  logic              RST;
  logic              UART_TXD, UART_RXD, UART_RTS, UART_CTS;
  logic [15:0]       CFG_DIV;
  logic [3:0]        CFG_DATA_BITS;
  logic [1:0]        CFG_PARITY;
  logic              CFG_STOP2, FLOW_EN;
  logic [7:0]        TX_DATA;
  logic              TX_VALID, TX_READY;
  logic [7:0]        RX_DATA;
  logic              RX_PERR, RX_FERR, RX_VALID, RX_READY, RX_OVERRUN, ERR_CLR;
  logic [FIFO_AW:0]  TX_LEVEL, RX_LEVEL;

  logic       loop_en, rxd_inj;
  int         checks = 0;
  int         failures = 0;
  logic [9:0] exp_q[$];
  logic [9:0] mon_e;

  assign UART_RXD = loop_en ? UART_TXD : rxd_inj;

  always #5 CLK = ~CLK;

  uart_fifo_core #(.FIFO_AW(FIFO_AW), .RTS_THRESH(12)) dut (
    .CLK(CLK), .RST(RST),
    .UART_TXD(UART_TXD), .UART_RXD(UART_RXD), .UART_RTS(UART_RTS), .UART_CTS(UART_CTS),
    .CFG_DIV(CFG_DIV), .CFG_DATA_BITS(CFG_DATA_BITS), .CFG_PARITY(CFG_PARITY),
    .CFG_STOP2(CFG_STOP2), .FLOW_EN(FLOW_EN),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .RX_DATA(RX_DATA), .RX_PERR(RX_PERR), .RX_FERR(RX_FERR), .RX_VALID(RX_VALID),
    .RX_READY(RX_READY), .RX_OVERRUN(RX_OVERRUN), .ERR_CLR(ERR_CLR),
    .TX_LEVEL(TX_LEVEL), .RX_LEVEL(RX_LEVEL)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every RX FIFO pop is compared with the oldest expected entry.
  always @(negedge CLK) begin
    if (!RST && RX_VALID && RX_READY) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rx_unexpected: got %0h expected no entry", {RX_DATA, RX_PERR, RX_FERR});
      end else begin
        mon_e = exp_q.pop_front();
        check("rx_entry{data,perr,ferr}", {22'd0, RX_DATA, RX_PERR, RX_FERR}, {22'd0, mon_e});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic push_tx(input logic [7:0] d);
    int t = 0;
    while (!TX_READY && t < 5000) begin @(negedge CLK); t++; end
    check("tx_ready_wait", TX_READY, 1);
    TX_DATA  = d;
    TX_VALID = 1'b1;
    @(negedge CLK);
    TX_VALID = 1'b0;
  endtask

  // bits[i] is the expected level of serial bit i (start first); each must last exactly div clocks.
  task automatic tx_frame_check(input string nm, input logic [15:0] bits, input int nb, input int div);
    int t = 0;
    logic got;
    while (UART_TXD !== 1'b0 && t < 3000) begin @(negedge CLK); t++; end
    check({nm, "_start_seen"}, UART_TXD, 0);
    if (UART_TXD !== 1'b0) return;
    for (int i = 0; i < nb; i++) begin
      got = bits[i];
      for (int k = 0; k < div; k++) begin
        if (UART_TXD !== bits[i]) got = UART_TXD;
        @(negedge CLK);
      end
      check($sformatf("%s_bit%0d", nm, i), got, bits[i]);
    end
  endtask

  task automatic send_rx(input logic [15:0] bits, input int nb, input int div);
    for (int i = 0; i < nb; i++) begin
      rxd_inj = bits[i];
      repeat (div) @(negedge CLK);
    end
    rxd_inj = 1'b1;
  endtask

  task automatic wait_drain(input string nm);
    int t = 0;
    while ((exp_q.size() != 0 || RX_VALID) && t < 3000) begin @(negedge CLK); t++; end
    check({nm, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic wait_rx_level(input logic [FIFO_AW:0] lvl);
    int t = 0;
    while (RX_LEVEL != lvl && t < 3000) begin @(negedge CLK); t++; end
    check($sformatf("rx_level_reach_%0d", lvl), RX_LEVEL, lvl);
  endtask

  initial begin
    int   t, n;
    logic prev, saw_low;

    RST = 1'b1; loop_en = 1'b1; rxd_inj = 1'b1; UART_CTS = 1'b0;
    CFG_DIV = 16'd8; CFG_DATA_BITS = 4'd8; CFG_PARITY = 2'd0; CFG_STOP2 = 1'b0;
    FLOW_EN = 1'b0; TX_DATA = 8'h00; TX_VALID = 1'b0; RX_READY = 1'b1; ERR_CLR = 1'b0;
    cycles(3);

    check("rst_txd", UART_TXD, 1);
    check("rst_rts", UART_RTS, 1);
    check("rst_tx_ready", TX_READY, 1);
    check("rst_rx_valid", RX_VALID, 0);
    check("rst_rx_data", RX_DATA, 0);
    check("rst_perr_ferr", {RX_PERR, RX_FERR}, 0);
    check("rst_overrun", RX_OVERRUN, 0);
    check("rst_levels", {TX_LEVEL, RX_LEVEL}, 0);
    RST = 1'b0;
    cycles(3);

    // 8N1, DIV=8, 0xA5 looped back
    exp_q.push_back({8'hA5, 2'b00});
    push_tx(8'hA5);
    tx_frame_check("a5", {6'd0, 1'b1, 8'hA5, 1'b0}, 10, 8);
    wait_drain("a5");

    // 7O2: parity bit of 0x3C (four ones) is 1, two stop bits
    CFG_DATA_BITS = 4'd7; CFG_PARITY = 2'd2; CFG_STOP2 = 1'b1;
    exp_q.push_back({8'h3C, 2'b00});
    push_tx(8'h3C);
    tx_frame_check("3c", {5'd0, 2'b11, 1'b1, 7'h3C, 1'b0}, 11, 8);
    wait_drain("3c");

    // injected 8E1: wrong parity on 0x55, then 0x0F with stop=0
    loop_en = 1'b0;
    CFG_DATA_BITS = 4'd8; CFG_PARITY = 2'd1; CFG_STOP2 = 1'b0;
    cycles(4);
    exp_q.push_back({8'h55, 2'b10});
    exp_q.push_back({8'h0F, 2'b01});
    send_rx({5'd0, 1'b1, 1'b1, 8'h55, 1'b0}, 11, 8);
    send_rx({5'd0, 1'b0, 1'b0, 8'h0F, 1'b0}, 11, 8);
    cycles(4);
    wait_drain("inj");

    // 3-clock glitch at DIV=16 must be rejected
    CFG_DIV = 16'd16; CFG_PARITY = 2'd0; RX_READY = 1'b0;
    cycles(4);
    rxd_inj = 1'b0;
    cycles(3);
    rxd_inj = 1'b1;
    cycles(40);
    check("glitch_rx_level", RX_LEVEL, 0);
    check("glitch_rx_valid", RX_VALID, 0);

    // overflow with clamped config (DIV 2->4, bits 15->8, parity 3->none)
    loop_en = 1'b1;
    CFG_DIV = 16'd2; CFG_DATA_BITS = 4'd15; CFG_PARITY = 2'd3; CFG_STOP2 = 1'b0;
    FLOW_EN = 1'b1; UART_CTS = 1'b0;
    cycles(4);
    check("ovf_rts_low", UART_RTS, 0);
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back({8'h81 + 8'(i * 13), 2'b00});
      push_tx(8'h81 + 8'(i * 13));
    end
    wait_rx_level(5'd11);
    check("rts_at_11", UART_RTS, 0);
    wait_rx_level(5'd12);
    check("rts_latency_at_12", UART_RTS, 0);
    cycles(1);
    check("rts_after_12", UART_RTS, 1);
    t = 0;
    while (!RX_OVERRUN && t < 3000) begin @(negedge CLK); t++; end
    check("ovf_overrun_set", RX_OVERRUN, 1);
    check("ovf_rx_level", RX_LEVEL, 16);
    cycles(5);
    check("ovf_overrun_sticky", RX_OVERRUN, 1);
    ERR_CLR = 1'b1;
    cycles(1);
    ERR_CLR = 1'b0;
    check("ovf_err_clr", RX_OVERRUN, 0);
    RX_READY = 1'b1;
    wait_drain("ovf");
    cycles(2);
    check("ovf_rx_level_empty", RX_LEVEL, 0);
    check("ovf_rts_released", UART_RTS, 0);

    // CTS gating: held off, back-to-back release, then re-gated mid frame 2
    CFG_DIV = 16'd8; CFG_DATA_BITS = 4'd8; CFG_PARITY = 2'd0;
    UART_CTS = 1'b1;
    cycles(4);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({8'hFF, 2'b00});
      push_tx(8'hFF);
    end
    saw_low = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (UART_TXD !== 1'b1) saw_low = 1'b1;
      @(negedge CLK);
    end
    check("cts_hold_txd_idle", saw_low, 0);
    check("cts_hold_tx_level", TX_LEVEL, 3);
    UART_CTS = 1'b0;
    t = 0;
    while (UART_TXD !== 1'b0 && t < 200) begin @(negedge CLK); t++; end
    check("cts_frame1_start", UART_TXD, 0);
    n = 0; prev = 1'b0;
    while (n < 200) begin
      @(negedge CLK);
      n++;
      if (prev === 1'b1 && UART_TXD === 1'b0) break;
      prev = UART_TXD;
    end
    check("b2b_start_interval", n, 81);
    cycles(20);
    UART_CTS = 1'b1;
    cycles(150);
    check("cts_frame3_held_txd", UART_TXD, 1);
    check("cts_frame3_held_level", TX_LEVEL, 1);
    check("cts_two_frames_received", exp_q.size(), 1);
    UART_CTS = 1'b0;
    wait_drain("cts");
    check("cts_tx_level_empty", TX_LEVEL, 0);

    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
